// File: rtl/scan_decoder_pkg.sv
// Shared types and constants for the scan_decoder family.
// Imported by the top and by later decoder variants.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_onehot_decode.sv
// Combinational binary-to-one-hot decoder.
// Bit k of op is high when sel == k.
module onehot_decode #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]    sel,
  output logic [2**SEL_W-1:0] op
);

  for (genvar k = 0; k < 2**SEL_W; k++) begin : g_bit
    assign op[k] = (sel == SEL_W'(k));
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot select driver with direct and self-scanning modes.
// op/idx/wrap are all registered from the next-state values.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [SEL_W-1:0]    last,
  output logic [2**SEL_W-1:0] op,
  output logic [SEL_W-1:0]    idx,
  output logic                wrap
);

  localparam int            CW      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

  state_t              state, state_nx;
  logic [SEL_W-1:0]    idx_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [2**SEL_W-1:0] op_nx;
  logic                wrap_nx;

  always_comb begin
    state_nx = IDLE;
    idx_nx   = '0;
    cnt_nx   = '0;
    if (en) begin
      if (mode == MODE_DIRECT) begin
        state_nx = DIRECT;
        idx_nx   = sel;
      end else begin
        state_nx = SCAN;
        // Entering SCAN from elsewhere keeps the zeroed defaults: slot 0, fresh dwell.
        if (state == SCAN) begin
          if (cnt == CNT_MAX) begin
            idx_nx = (idx < last) ? idx + 1'b1 : '0;
          end else begin
            idx_nx = idx;
            cnt_nx = cnt + 1'b1;
          end
        end
      end
    end
  end

  onehot_decode #(.SEL_W(SEL_W)) u_dec (
    .sel (idx_nx),
    .op  (op_nx)
  );

  assign wrap_nx = (state_nx == SCAN) && (idx_nx >= last) && (cnt_nx == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      op    <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
      op    <= (state_nx == IDLE) ? '0 : op_nx;
      wrap  <= wrap_nx;
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: DWELL=4 and DWELL=1 instances share stimulus.
module tb_scan_decoder;
  import scan_decoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, en, mode;
  logic [2:0] sel, last;
  logic [7:0] op0, op1;
  logic [2:0] idx0, idx1;
  logic       wrap0, wrap1;

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(3), .DWELL(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .last(last),
    .op(op0), .idx(idx0), .wrap(wrap0)
  );

  scan_decoder #(.SEL_W(3), .DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .last(last),
    .op(op1), .idx(idx1), .wrap(wrap1)
  );

  typedef struct {
    logic [7:0] op;
    logic [2:0] idx;
    logic       wrap;
  } exp_t;

  exp_t q0[$], q1[$];
  int   n_chk = 0, n_pass = 0;
  int   m_st[2], m_idx[2], m_cnt[2];
  int   dw[2] = '{4, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = 0; m_idx[d] = 0; m_cnt[d] = 0;
    end
  endtask

  // Reference: 0=idle 1=direct 2=scan; advances one edge with the current inputs.
  task automatic model(input int d, output exp_t e);
    if (!en) begin
      m_st[d] = 0; m_idx[d] = 0; m_cnt[d] = 0;
    end else if (mode == MODE_DIRECT) begin
      m_st[d] = 1; m_idx[d] = int'(sel); m_cnt[d] = 0;
    end else if (m_st[d] != 2) begin
      m_st[d] = 2; m_idx[d] = 0; m_cnt[d] = 0;
    end else if (m_cnt[d] == dw[d] - 1) begin
      m_cnt[d] = 0;
      m_idx[d] = (m_idx[d] < int'(last)) ? m_idx[d] + 1 : 0;
    end else begin
      m_cnt[d] = m_cnt[d] + 1;
    end
    e.idx  = 3'(m_idx[d]);
    e.op   = (m_st[d] == 0) ? 8'h00 : 8'(1 << m_idx[d]);
    e.wrap = (m_st[d] == 2) && (m_idx[d] >= int'(last)) && (m_cnt[d] == dw[d] - 1);
  endtask

  task automatic step();
    exp_t e;
    model(0, e); q0.push_back(e);
    model(1, e); q1.push_back(e);
    @(posedge clk); #1;
    e = q0.pop_front();
    chk("sb_op0", op0, e.op); chk("sb_idx0", idx0, e.idx); chk("sb_wrap0", wrap0, e.wrap);
    e = q1.pop_front();
    chk("sb_op1", op1, e.op); chk("sb_idx1", idx1, e.idx); chk("sb_wrap1", wrap1, e.wrap);
  endtask

  initial begin
    int nw;
    rst_n = 1'b0; en = 1'b0; mode = MODE_DIRECT; sel = '0; last = '0;
    model_reset();
    #12;
    chk("rst_op", op0, 8'h00); chk("rst_idx", idx0, 3'd0); chk("rst_wrap", wrap0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Direct decode and one-cycle enable latency
    en = 1'b1; sel = 3'd3;
    step();
    chk("direct3", op0, 8'h08);
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      step();
      chk("sweep_op", op0, 32'h1 << i);
      chk("sweep_wrap", wrap0, 1'b0);
    end

    // Scan DWELL=4, last=5: wrap only at cycles 24 and 48
    last = 3'd5; mode = MODE_SCAN; nw = 0;
    for (int c = 1; c <= 48; c++) begin
      step();
      if (wrap0) begin nw++; chk("wrap_cyc", c % 24, 0); end
      if (c == 1 || c == 25) chk("scan_start", idx0, 3'd0);
      if (c == 21) chk("scan_slot5", op0, 8'h20);
    end
    chk("wrap_cnt", nw, 2);

    // last = 0: slot 0 pinned, wrap every DWELL cycles
    mode = MODE_DIRECT; step();
    last = 3'd0; mode = MODE_SCAN; nw = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("last0_op", op0, 8'h01);
      if (wrap0) nw++;
    end
    chk("last0_wraps", nw, 3);

    // DWELL=1, last=7: index steps every cycle and wraps 7->0
    mode = MODE_DIRECT; step();
    last = 3'd7; mode = MODE_SCAN;
    for (int c = 1; c <= 9; c++) begin
      step();
      chk("d1_idx", idx1, (c - 1) % 8);
      chk("d1_wrap", wrap1, c == 8);
    end

    // Lower last 6->2 while on slot 4
    mode = MODE_DIRECT; step();
    last = 3'd6; mode = MODE_SCAN;
    for (int c = 1; c <= 21; c++) begin
      step();
      if (c == 17) begin chk("low_idx4", idx0, 3'd4); last = 3'd2; end
      if (c == 20) chk("low_wrap", wrap0, 1'b1);
      if (c == 21) chk("low_to0", idx0, 3'd0);
    end

    // en low mid-scan, then restart at slot 0
    step(); step();
    en = 1'b0; step();
    chk("en_off", op0, 8'h00);
    en = 1'b1; step();
    chk("en_on_idx", idx0, 3'd0);
    chk("en_on_op", op0, 8'h01);
    step(); step();

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_op", op0, 8'h00); chk("arst_idx", idx0, 3'd0); chk("arst_wrap", wrap0, 1'b0);
    chk("arst_op1", op1, 8'h00);
    model_reset();
    #1 rst_n = 1'b1;
    step();
    chk("arst_restart", op0, 8'h01);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Registered, parametrised binary-to-one-hot decoder with a built-in scan sequencer. It drives the select lines of multiplexed peripherals, such as display digits or keypad rows. In DIRECT mode it decodes a host-supplied index. In SCAN mode it steps its own index from 0 to a programmable last slot, holding each slot for DWELL clock cycles and flagging each wrap-around.

## Interface
- SEL_W, 3: index width; output width is 2**SEL_W (SEL_W >= 1)
- DWELL, 4: cycles each slot stays active in SCAN mode (DWELL >= 1)
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  reset, asynchronous assert, active-low
- en  input  1  block enable; low forces all outputs inactive
- mode  input  1  0 = DIRECT, 1 = SCAN
- sel  input  SEL_W  index decoded in DIRECT mode
- last  input  SEL_W  highest slot visited in SCAN mode
- op  output  2**SEL_W  one-hot select, registered; bit k high selects slot k
- idx  output  SEL_W  binary index currently driven on op, registered
- wrap  output  1  one-cycle pulse during the final dwell cycle of slot `last`

## Operation
- Reset (rst_n low, any time): state IDLE, op = 0, idx = 0, wrap = 0, dwell counter = 0. Takes effect immediately and asynchronously, including mid-scan.
- States: IDLE, DIRECT, SCAN. Next state is evaluated every cycle:
  - en = 0 gives IDLE.
  - en = 1 and mode = 0 gives DIRECT.
  - en = 1 and mode = 1 gives SCAN.
- IDLE: op = 0, wrap = 0. idx and the dwell counter are cleared to 0.
- DIRECT: each cycle, idx <= sel and op <= onehot(sel). wrap = 0. The dwell counter is held at 0.
- SCAN, entered from any other state: the first active slot is 0 with a fresh dwell count. Otherwise:
  - The dwell counter counts 0 .. DWELL-1.
  - When the counter reaches DWELL-1, idx advances: idx+1 if idx < last, else 0.
  - op always equals onehot(idx). Exactly one op bit is high in SCAN.
- `last` is sampled only at slot advance.
  - If `last` is lowered below the current idx mid-scan, the next advance goes to 0 and wrap pulses then.
  - last = 0: slot 0 is permanently active, and wrap pulses every DWELL cycles.
- wrap: registered. It is high for exactly the cycle in which idx >= last and the dwell counter = DWELL-1. It is never high outside SCAN.
- DWELL = 1: idx advances every cycle, and the dwell counter is constant 0.
- Mode change SCAN to DIRECT: the next cycle shows onehot(sel), and scan position is lost.
- Mode change DIRECT to SCAN: the next cycle shows slot 0 with dwell count 0.
- Arithmetic:
  - idx increments are SEL_W bits wide and never overflow, because the compare against `last` precedes the increment.
  - The dwell counter width is max(1, $clog2(DWELL)).

## Timing
- All outputs are registered; there is no combinational path from input to output.
- DIRECT latency: sel sampled at edge N appears on op/idx after edge N.
- Enable latency: en rising at edge N gives the first active op after edge N. en falling at edge N gives op = 0 after edge N.
- SCAN period: each slot is active for DWELL cycles, so a full cycle is (last+1)*DWELL cycles.
- Simultaneous events:
  - en low overrides mode.
  - A mode change on the same edge as a slot advance follows the new mode's rule.
- No handshake. Inputs are assumed synchronous to clk.

## Structure
- Shared package scan_decoder_pkg holds:
  - state enum (IDLE, DIRECT, SCAN)
  - mode constants MODE_DIRECT = 1'b0, MODE_SCAN = 1'b1
- Sub-module onehot_decode: purely combinational, parametrised SEL_W, maps binary to one-hot. It is reused by the scan_decoder top and by future decoder variants.
- The top holds the state register, idx register, dwell counter, and output registers.

## Test plan
- Reset/enable: rst_n low → op = 0, idx = 0, wrap = 0. Then en = 1, mode = 0, sel = 3 → op = 8'b00001000 one cycle later.
- DIRECT sweep (SEL_W = 3): sel = 0..7 on consecutive cycles → op = 8'h01, 02, 04 … 80 at one-cycle latency. wrap stays 0.
- SCAN (DWELL = 4, last = 5): op walks slots 0..5, holding each for 4 cycles, then returns to 0. wrap is high only in cycle 24, then again in cycle 48.
- Boundaries:
  - last = 0 → op = 8'h01 constantly, wrap every 4 cycles.
  - DWELL = 1, last = 7 → idx increments every cycle and wraps 7→0.
- Mid-operation:
  - Lower last from 6 to 2 while idx = 4 → next advance goes to 0 with wrap.
  - en low mid-scan → op = 0 next cycle, and re-enable restarts at slot 0.
  - rst_n pulse mid-scan → outputs clear asynchronously.
